// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    localparam int CNT_LAT_W  = 4;
    localparam int ADDR_W_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } haz_state_e;

    // r0 is hard-wired to zero, so a match on address 0 is never a real dependency.
    function automatic logic addr_hit(input logic [ADDR_W_MAX-1:0] a,
                                      input logic [ADDR_W_MAX-1:0] b);
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side signal bundle for hazard_ctrl_unit; master = pipeline, slave = hazard unit.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              id_ex_memread_i;
    logic              id_ex_regwrite_i;
    logic [REG_AW-1:0] id_ex_rd_i;
    logic              ex_mem_memread_i;
    logic [REG_AW-1:0] ex_mem_rd_i;
    logic [REG_AW-1:0] if_id_rs_i;
    logic [REG_AW-1:0] if_id_rt_i;
    logic              if_id_use_rt_i;
    logic              beq_i;
    logic              bne_i;
    logic              jump_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic              dmem_busy_i;
    logic              pc_write_o;
    logic              if_id_write_o;
    logic              ctrl_sel_o;
    logic              flush_o;
    logic              freeze_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_ex_memread_i, id_ex_regwrite_i, id_ex_rd_i, ex_mem_memread_i, ex_mem_rd_i,
               if_id_rs_i, if_id_rt_i, if_id_use_rt_i, beq_i, bne_i, jump_i,
               rs_data_i, rt_data_i, dmem_busy_i,
        input  pc_write_o, if_id_write_o, ctrl_sel_o, flush_o, freeze_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_ex_memread_i, id_ex_regwrite_i, id_ex_rd_i, ex_mem_memread_i, ex_mem_rd_i,
               if_id_rs_i, if_id_rt_i, if_id_use_rt_i, beq_i, bne_i, jump_i,
               rs_data_i, rt_data_i, dmem_busy_i,
        output pc_write_o, if_id_write_o, ctrl_sel_o, flush_o, freeze_o,
               stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard performance statistics.
module hazard_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: load-use, branch-operand and dmem-busy handling.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
//
// state   | meaning
// IDLE    | no multi-cycle hazard pending
// LDSTALL | load-use stall in progress, r_cnt cycles remaining
// MEMWAIT | data memory busy; pipeline frozen, r_ret_state resumes afterwards
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DATA_W   = 32,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_ctrl_unit_if.slave bus
);

    localparam bit LD_MULTI = (LOAD_LAT > 1);

    haz_state_e           r_state;
    haz_state_e           r_ret_state;
    logic [CNT_LAT_W-1:0] r_cnt;

    logic [REG_AW-1:0] w_id_ex_rd, w_ex_mem_rd, w_rs, w_rt;
    logic [DATA_W-1:0] w_rs_data, w_rt_data;
    logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
    logic w_lu, w_br, w_eq, w_tkn, w_freeze, w_stall;
    logic w_pc_write, w_if_id_write, w_ctrl_sel, w_flush, w_freeze_o;

    assign w_id_ex_rd  = bus.id_ex_rd_i;
    assign w_ex_mem_rd = bus.ex_mem_rd_i;
    assign w_rs        = bus.if_id_rs_i;
    assign w_rt        = bus.if_id_rt_i;
    assign w_rs_data   = bus.rs_data_i;
    assign w_rt_data   = bus.rt_data_i;

    assign w_rs_ex  = addr_hit(ADDR_W_MAX'(w_id_ex_rd), ADDR_W_MAX'(w_rs));
    assign w_rt_ex  = addr_hit(ADDR_W_MAX'(w_id_ex_rd), ADDR_W_MAX'(w_rt));
    assign w_rs_mem = addr_hit(ADDR_W_MAX'(w_ex_mem_rd), ADDR_W_MAX'(w_rs));
    assign w_rt_mem = addr_hit(ADDR_W_MAX'(w_ex_mem_rd), ADDR_W_MAX'(w_rt));

    assign w_lu  = bus.id_ex_memread_i & (w_rs_ex | (bus.if_id_use_rt_i & w_rt_ex));
    assign w_br  = (bus.beq_i | bus.bne_i)
                 & ((bus.id_ex_regwrite_i & (w_rs_ex | w_rt_ex))
                  | (bus.ex_mem_memread_i & (w_rs_mem | w_rt_mem)));
    assign w_eq  = (w_rs_data == w_rt_data);
    assign w_tkn = (bus.beq_i & w_eq) | (bus.bne_i & ~w_eq) | bus.jump_i;

    assign w_freeze = bus.dmem_busy_i | (r_state == MEMWAIT);
    assign w_stall  = w_lu | w_br | (r_state == LDSTALL);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_ret_state <= IDLE;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.dmem_busy_i) begin
                        r_state     <= MEMWAIT;
                        r_ret_state <= IDLE;
                    end else if (w_lu && LD_MULTI) begin
                        r_state <= LDSTALL;
                        r_cnt   <= CNT_LAT_W'(LOAD_LAT - 1);
                    end
                end
                LDSTALL: begin
                    // A busy memory suspends the countdown; r_cnt resumes where it left off.
                    if (bus.dmem_busy_i) begin
                        r_state     <= MEMWAIT;
                        r_ret_state <= LDSTALL;
                    end else begin
                        if (r_cnt == CNT_LAT_W'(1)) r_state <= IDLE;
                        r_cnt <= r_cnt - CNT_LAT_W'(1);
                    end
                end
                MEMWAIT: begin
                    if (!bus.dmem_busy_i) r_state <= r_ret_state;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_ctrl_sel    = 1'b0;
        w_flush       = 1'b0;
        w_freeze_o    = 1'b0;
        if (rst_i) begin
            if (w_freeze) begin
                w_freeze_o = 1'b1;
                w_ctrl_sel = 1'b1;
            end else if (!w_stall) begin
                w_pc_write    = 1'b1;
                w_if_id_write = 1'b1;
                w_ctrl_sel    = 1'b1;
                w_flush       = w_tkn;
            end
        end
    end

    assign bus.pc_write_o    = w_pc_write;
    assign bus.if_id_write_o = w_if_id_write;
    assign bus.ctrl_sel_o    = w_ctrl_sel;
    assign bus.flush_o       = w_flush;
    assign bus.freeze_o      = w_freeze_o;

`ifdef HAZ_PERF_CNT_EN
    logic w_stall_evt;
    assign w_stall_evt = rst_i & (w_freeze | w_stall);

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_inc   (w_stall_evt),
        .o_cnt   (bus.stall_cnt_o)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_inc   (w_flush),
        .o_cnt   (bus.flush_cnt_o)
    );
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
    assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LOAD_LAT 1 and 3) share one directed stimulus stream.
module tb_hazard_ctrl_unit;

    localparam int RA = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_memread = 0, s_regwrite = 0, s_exm_memread = 0;
    logic [RA-1:0] s_idex_rd = 0, s_exm_rd = 0, s_rs = 0, s_rt = 0;
    logic          s_use_rt = 0, s_beq = 0, s_bne = 0, s_jump = 0, s_busy = 0;
    logic [DW-1:0] s_rs_data = 0, s_rt_data = 0;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_ctrl_unit_if #(.REG_AW(RA), .DATA_W(DW), .CNT_W(CW)) b1 ();
    hazard_ctrl_unit_if #(.REG_AW(RA), .DATA_W(DW), .CNT_W(CW)) b3 ();

    hazard_ctrl_unit #(.REG_AW(RA), .DATA_W(DW), .LOAD_LAT(1), .CNT_W(CW)) dut1 (
        .clk_i (clk), .rst_i (rst_n), .bus (b1));
    hazard_ctrl_unit #(.REG_AW(RA), .DATA_W(DW), .LOAD_LAT(3), .CNT_W(CW)) dut3 (
        .clk_i (clk), .rst_i (rst_n), .bus (b3));

    assign b1.id_ex_memread_i  = s_memread;     assign b3.id_ex_memread_i  = s_memread;
    assign b1.id_ex_regwrite_i = s_regwrite;    assign b3.id_ex_regwrite_i = s_regwrite;
    assign b1.id_ex_rd_i       = s_idex_rd;     assign b3.id_ex_rd_i       = s_idex_rd;
    assign b1.ex_mem_memread_i = s_exm_memread; assign b3.ex_mem_memread_i = s_exm_memread;
    assign b1.ex_mem_rd_i      = s_exm_rd;      assign b3.ex_mem_rd_i      = s_exm_rd;
    assign b1.if_id_rs_i       = s_rs;          assign b3.if_id_rs_i       = s_rs;
    assign b1.if_id_rt_i       = s_rt;          assign b3.if_id_rt_i       = s_rt;
    assign b1.if_id_use_rt_i   = s_use_rt;      assign b3.if_id_use_rt_i   = s_use_rt;
    assign b1.beq_i            = s_beq;         assign b3.beq_i            = s_beq;
    assign b1.bne_i            = s_bne;         assign b3.bne_i            = s_bne;
    assign b1.jump_i           = s_jump;        assign b3.jump_i           = s_jump;
    assign b1.rs_data_i        = s_rs_data;     assign b3.rs_data_i        = s_rs_data;
    assign b1.rt_data_i        = s_rt_data;     assign b3.rt_data_i        = s_rt_data;
    assign b1.dmem_busy_i      = s_busy;        assign b3.dmem_busy_i      = s_busy;

    // {pc_write, if_id_write, ctrl_sel, flush, freeze}
    wire [4:0] o1 = {b1.pc_write_o, b1.if_id_write_o, b1.ctrl_sel_o, b1.flush_o, b1.freeze_o};
    wire [4:0] o3 = {b3.pc_write_o, b3.if_id_write_o, b3.ctrl_sel_o, b3.flush_o, b3.freeze_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ld1 = 0, ld3 = 0;   // extra load-stall cycles still owed
    bit mw  = 0;            // memory wait: frozen this cycle even if busy already dropped
    int sc1 = 0, sc3 = 0, fc1 = 0, fc3 = 0;

    function automatic bit m_lu();
        return s_memread && (s_idex_rd != 0)
            && ((s_idex_rd == s_rs) || (s_use_rt && (s_idex_rd == s_rt)));
    endfunction

    function automatic bit m_br();
        bit ex_dep, mem_dep;
        ex_dep  = s_regwrite && (s_idex_rd != 0) && ((s_idex_rd == s_rs) || (s_idex_rd == s_rt));
        mem_dep = s_exm_memread && (s_exm_rd != 0) && ((s_exm_rd == s_rs) || (s_exm_rd == s_rt));
        return (s_beq || s_bne) && (ex_dep || mem_dep);
    endfunction

    function automatic logic [4:0] mexp(int ld, bit m);
        bit tkn;
        tkn = (s_beq && (s_rs_data == s_rt_data)) || (s_bne && (s_rs_data != s_rt_data)) || s_jump;
        if (!rst_n) return 5'b00000;
        if (s_busy || m) return 5'b00101;
        if (m_lu() || m_br() || ld > 0) return 5'b00000;
        return {3'b111, tkn, 1'b0};
    endfunction

    function automatic int nld(int ld, int lat, bit frz);
        if (frz) return ld;
        if (ld > 0) return ld - 1;
        if (m_lu()) return lat - 1;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        logic [4:0] e1, e3;
        bit frz;
        if (!rst_n) begin
            ld1 <= 0; ld3 <= 0; mw <= 0;
            sc1 <= 0; sc3 <= 0; fc1 <= 0; fc3 <= 0;
        end else begin
            e1  = mexp(ld1, mw);
            e3  = mexp(ld3, mw);
            frz = s_busy || mw;
            mw  <= s_busy;
            ld1 <= nld(ld1, 1, frz);
            ld3 <= nld(ld3, 3, frz);
            sc1 <= sc1 + (e1[4] ? 0 : 1);
            sc3 <= sc3 + (e3[4] ? 0 : 1);
            fc1 <= fc1 + (e1[1] ? 1 : 0);
            fc3 <= fc3 + (e3[1] ? 1 : 0);
        end
    end

    always @(negedge clk) begin : compare
        chk("cmp_out_lat1", 32'(o1), 32'(mexp(ld1, mw)));
        chk("cmp_out_lat3", 32'(o3), 32'(mexp(ld3, mw)));
`ifdef HAZ_PERF_CNT_EN
        chk("cmp_stall_cnt_lat1", 32'(b1.stall_cnt_o), 32'(sc1));
        chk("cmp_stall_cnt_lat3", 32'(b3.stall_cnt_o), 32'(sc3));
        chk("cmp_flush_cnt_lat1", 32'(b1.flush_cnt_o), 32'(fc1));
        chk("cmp_flush_cnt_lat3", 32'(b3.flush_cnt_o), 32'(fc3));
`else
        chk("cmp_stall_cnt_tied", 32'(b1.stall_cnt_o | b3.stall_cnt_o), 32'd0);
        chk("cmp_flush_cnt_tied", 32'(b1.flush_cnt_o | b3.flush_cnt_o), 32'd0);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        s_memread = 0; s_regwrite = 0; s_exm_memread = 0;
        s_idex_rd = 0; s_exm_rd = 0; s_rs = 0; s_rt = 0;
        s_use_rt = 0; s_beq = 0; s_bne = 0; s_jump = 0; s_busy = 0;
        s_rs_data = 0; s_rt_data = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            nx();
            clr();
        end
    endtask

    bit [3:0] lat3_pc = 4'b1000;      // stall, stall, stall, run
    bit [6:0] frz_seq = 7'b0001110;   // freeze on cycles 1..3
    bit [6:0] pc_seq  = 7'b1000000;   // pc held until cycle 6

    initial begin
        clr();
        rst_n = 0;
        @(negedge clk);
        chk("reset_out_lat1", 32'(o1), 32'd0);
        chk("reset_out_lat3", 32'(o3), 32'd0);
        nx(); rst_n = 1;
        @(negedge clk);
        chk("idle_out_lat1", 32'(o1), 32'b11100);

        // lw r2 in EX, ID reads r2; afterwards EX holds the bubble
        for (int i = 0; i < 4; i++) begin
            nx(); clr(); s_rs = 2;
            if (i == 0) begin s_memread = 1; s_idex_rd = 2; end
            @(negedge clk);
            if (i == 0) begin
                chk("t1_pc_lat1", 32'(b1.pc_write_o), 32'd0);
                chk("t1_ctrl_lat1", 32'(b1.ctrl_sel_o), 32'd0);
            end
            if (i == 1) chk("t1_resume_lat1", 32'(b1.pc_write_o), 32'd1);
            chk($sformatf("t2_pc_lat3_c%0d", i), 32'(b3.pc_write_o), 32'(lat3_pc[i]));
        end

        // same load-use with dmem busy on the 2nd stall cycle for 2 cycles
        for (int i = 0; i < 7; i++) begin
            nx(); clr(); s_rs = 2;
            if (i == 0) begin s_memread = 1; s_idex_rd = 2; end
            if (i == 1 || i == 2) s_busy = 1;
            @(negedge clk);
            chk($sformatf("t2_frz_lat3_c%0d", i), 32'(b3.freeze_o), 32'(frz_seq[i]));
            chk($sformatf("t2_pcw_lat3_c%0d", i), 32'(b3.pc_write_o), 32'(pc_seq[i]));
        end

        // r0 exclusion and rt only when used
        nx(); clr(); s_memread = 1; s_idex_rd = 0; s_rs = 0;
        @(negedge clk);
        chk("t3_r0_lat1", 32'(b1.pc_write_o), 32'd1);
        chk("t3_r0_lat3", 32'(b3.pc_write_o), 32'd1);
        nx(); clr(); s_memread = 1; s_idex_rd = 3; s_rt = 3; s_rs = 4; s_use_rt = 0;
        @(negedge clk);
        chk("t3_nort_lat1", 32'(b1.pc_write_o), 32'd1);
        nx(); s_use_rt = 1;
        @(negedge clk);
        chk("t3_rt_lat1", 32'(o1), 32'b00000);
        idle(4);

        // add r5 in EX; beq r5,r6 in ID with equal data
        nx(); clr(); s_regwrite = 1; s_idex_rd = 5; s_beq = 1; s_rs = 5; s_rt = 6;
        s_rs_data = 42; s_rt_data = 42;
        @(negedge clk);
        chk("t4_stall_pc", 32'(b1.pc_write_o), 32'd0);
        chk("t4_stall_flush", 32'(b1.flush_o), 32'd0);
        nx(); s_regwrite = 0; s_idex_rd = 0;
        @(negedge clk);
        chk("t4_taken_flush", 32'(b1.flush_o), 32'd1);
        chk("t4_taken_pc", 32'(b1.pc_write_o), 32'd1);

        // branch after load: stall via EX, then via EX/MEM, then resolve
        nx(); clr(); s_memread = 1; s_regwrite = 1; s_idex_rd = 5; s_beq = 1; s_rs = 5; s_rt = 6;
        s_rs_data = 9; s_rt_data = 9;
        @(negedge clk);
        chk("t4_ld_br_c0", 32'(b1.pc_write_o), 32'd0);
        nx(); s_memread = 0; s_regwrite = 0; s_idex_rd = 0; s_exm_memread = 1; s_exm_rd = 5;
        @(negedge clk);
        chk("t4_ld_br_c1", 32'(o1), 32'b00000);
        nx(); s_exm_memread = 0; s_exm_rd = 0;
        @(negedge clk);
        chk("t4_ld_br_c2", 32'(o1), 32'b11110);
        idle(4);

        // isolate flush counting with a reset pulse
        nx(); rst_n = 0;
        nx(); rst_n = 1;
        nx(); clr(); s_bne = 1; s_rs = 7; s_rt = 7; s_rs_data = 7; s_rt_data = 7;
        @(negedge clk);
        chk("t5_bne_eq_flush", 32'(b1.flush_o), 32'd0);
        chk("t5_bne_eq_pc", 32'(b1.pc_write_o), 32'd1);
        nx(); clr(); s_jump = 1;
        @(negedge clk);
        chk("t5_jump_flush", 32'(b1.flush_o), 32'd1);
        nx(); clr();
        @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
        chk("t5_flush_cnt", 32'(b1.flush_cnt_o), 32'd1);
`else
        chk("t5_flush_cnt_tied", 32'(b1.flush_cnt_o), 32'd0);
`endif

        // reset in the middle of a multi-cycle load stall
        nx(); clr(); s_memread = 1; s_idex_rd = 2; s_rs = 2;
        @(negedge clk);
        nx(); clr(); s_rs = 2;
        @(negedge clk);
        chk("t6_in_ldstall", 32'(b3.pc_write_o), 32'd0);
        nx(); rst_n = 0;
        @(negedge clk);
        chk("t6_reset_out_lat3", 32'(o3), 32'd0);
        nx(); rst_n = 1;
        @(negedge clk);
        chk("t6_release_lat3", 32'(o3), 32'b11100);
        nx();
        @(negedge clk);
        chk("t6_no_residual_lat3", 32'(b3.pc_write_o), 32'd1);
        idle(2);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
